// File: rtl/div_sequencer_pkg.sv
// Shared opcodes and state encoding for the multi-cycle divide sequencer.
package div_sequencer_pkg;

   // ALU control codes that select a divide; every other code is left to the single-cycle ALU
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   // Sequencer states, encoded in two bits
   typedef enum logic [1:0] {
      DIVS_IDLE = 2'b00,
      DIVS_BUSY = 2'b01,
      DIVS_DONE = 2'b10
   } divState_t;

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational radix-2 restoring divide iteration.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_div,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_shifted;
   logic [WIDTH+1:0] w_trial;

   // Shift {rem,quo} left by one and subtract the divisor from the upper half.
   // The shifted remainder can need WIDTH+1 bits when the divisor is above 2^(WIDTH-1),
   // so the trial runs two bits wider. A non-negative trial is always below the divisor,
   // so both top bits of the trial are zero exactly when the subtraction is kept.
   always_comb begin
      w_shifted = {i_rem, i_quo[WIDTH-1]};
      w_trial   = {1'b0, w_shifted} - {2'b00, i_div};
      o_quo     = {i_quo[WIDTH-2:0], 1'b0};
      o_rem     = w_shifted[WIDTH-1:0];
      if (w_trial[WIDTH+1:WIDTH] == 2'b00) begin
         o_rem    = w_trial[WIDTH-1:0];
         o_quo[0] = 1'b1;
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: accepts one request, runs WIDTH
// restoring iterations while stalling the front of the pipe, then pulses valid for one
// cycle with the sign-corrected quotient (LO) and remainder (HI).
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req,
   input  logic [7:0]       alucontrol,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             stall,
   output logic             valid,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   divState_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic             r_negQ;
   logic             r_negR;
   logic             r_valid;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_isDiv;
   logic             w_signed;
   logic             w_accept;
   logic             w_divisorZero;
   logic [WIDTH-1:0] w_dividendAbs;
   logic [WIDTH-1:0] w_divisorAbs;
   logic [WIDTH-1:0] w_remNext;
   logic [WIDTH-1:0] w_quoNext;
   logic [WIDTH-1:0] w_quoFixed;
   logic [WIDTH-1:0] w_remFixed;

   // Request decode, operand magnitudes and sign correction of the final iteration.
   // Accept is gated by resetn so stall reads zero while the block is held in reset.
   always_comb begin
      w_isDiv       = (alucontrol == EXE_DIV_OP) || (alucontrol == EXE_DIVU_OP);
      w_signed      = (alucontrol == EXE_DIV_OP);
      w_accept      = resetn && (r_state == DIVS_IDLE) && req && !cancel && w_isDiv;
      w_divisorZero = (divisor == '0);
      w_dividendAbs = (w_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
      w_divisorAbs  = (w_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
      w_quoFixed    = r_negQ ? (~w_quoNext + 1'b1) : w_quoNext;
      w_remFixed    = r_negR ? (~w_remNext + 1'b1) : w_remNext;
      stall         = w_accept || ((r_state == DIVS_BUSY) && !cancel);
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_remNext),
      .o_quo (w_quoNext)
   );

   // Sequencer FSM with its iteration registers and registered result outputs.
   // Results are only overwritten when an operation completes, so a cancelled divide
   // leaves the previous quotient/remainder visible; the zero flag clears on any accept.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= DIVS_IDLE;
         r_cnt       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_negQ      <= 1'b0;
         r_negR      <= 1'b0;
         r_valid     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            DIVS_IDLE: begin
               if (w_accept) begin
                  if (w_divisorZero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_dbz       <= 1'b1;
                     r_valid     <= 1'b1;
                     r_state     <= DIVS_DONE;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_dividendAbs;
                     r_div   <= w_divisorAbs;
                     r_negQ  <= w_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     r_negR  <= w_signed && dividend[WIDTH-1];
                     r_cnt   <= '0;
                     r_dbz   <= 1'b0;
                     r_state <= DIVS_BUSY;
                  end
               end
            end
            DIVS_BUSY: begin
               if (cancel) begin
                  r_cnt   <= '0;
                  r_state <= DIVS_IDLE;
               end else begin
                  r_rem <= w_remNext;
                  r_quo <= w_quoNext;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LastCnt) begin
                     r_quotient  <= w_quoFixed;
                     r_remainder <= w_remFixed;
                     r_valid     <= 1'b1;
                     r_state     <= DIVS_DONE;
                  end
               end
            end
            DIVS_DONE: begin
               r_state <= DIVS_IDLE;
            end
            default: begin
               r_state <= DIVS_IDLE;
            end
         endcase
      end
   end

   // Outputs come straight from their registers
   always_comb begin
      valid       = r_valid;
      quotient    = r_quotient;
      remainder   = r_remainder;
      div_by_zero = r_dbz;
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a vector table of divides with hand-computed
// results and latencies, plus hand-written cancel, reset and back-to-back sequences.
module tb_div_sequencer;
   import div_sequencer_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          resetn;
   logic          req;
   logic [7:0]    alucontrol;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          cancel;
   logic          stall;
   logic          valid;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int total = 0;
   int bad   = 0;
   int cycleCount = 0;

   typedef struct {
      logic [7:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      int           lat;
   } divVec_t;

   divVec_t vecs [11];

   div_sequencer #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .alucontrol  (alucontrol),
      .dividend    (dividend),
      .divisor     (divisor),
      .cancel      (cancel),
      .stall       (stall),
      .valid       (valid),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure spacing between valid pulses
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
   end

   // Compare one value and log it on mismatch
   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a divide at a negative edge and confirm it is accepted (stall rises)
   task automatic applyStimulus(input string name, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      req        = 1'b1;
      cancel     = 1'b0;
      alucontrol = op;
      dividend   = a;
      divisor    = b;
      #1;
      checkOutput({name, "_acceptStall"}, {31'b0, stall}, 32'd1);
   endtask

   // Hold req until valid appears, then check latency, stall length and results
   task automatic waitResult(input string name, input logic [W-1:0] expQ, input logic [W-1:0] expR,
                             input logic expDbz, input int expLat, output int validCycle);
      int n        = 0;
      int stallCnt = 1;
      bit seen     = 0;
      while (!seen && n < 80) begin
         @(negedge clk);
         n++;
         if (valid) seen = 1;
         else if (stall) stallCnt++;
      end
      req = 1'b0;
      validCycle = cycleCount;
      checkOutput({name, "_validSeen"}, {31'b0, seen}, 32'd1);
      checkOutput({name, "_latency"}, n, expLat);
      checkOutput({name, "_stallCycles"}, stallCnt, expLat);
      checkOutput({name, "_stallAtValid"}, {31'b0, stall}, 32'd0);
      checkOutput({name, "_quotient"}, quotient, expQ);
      checkOutput({name, "_remainder"}, remainder, expR);
      checkOutput({name, "_dbz"}, {31'b0, div_by_zero}, {31'b0, expDbz});
   endtask

   initial begin
      int vc1;
      int vc2;
      logic [W-1:0] lastQ;
      logic [W-1:0] lastR;

      vecs[0]  = '{EXE_DIVU_OP, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
      vecs[1]  = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
      vecs[2]  = '{EXE_DIV_OP,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
      vecs[3]  = '{EXE_DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 33};
      vecs[4]  = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
      vecs[5]  = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0, 33};
      vecs[6]  = '{EXE_DIV_OP,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 33};
      vecs[7]  = '{EXE_DIV_OP,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 33};
      vecs[8]  = '{EXE_DIVU_OP, 32'h1234_5678,  32'h0000_0100,  32'h0012_3456,  32'h0000_0078,  1'b0, 33};
      vecs[9]  = '{EXE_DIVU_OP, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
      vecs[10] = '{EXE_DIVU_OP, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33};

      resetn     = 1'b0;
      req        = 1'b0;
      cancel     = 1'b0;
      alucontrol = 8'h00;
      dividend   = '0;
      divisor    = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_stall", {31'b0, stall}, 32'd0);
      checkOutput("reset_valid", {31'b0, valid}, 32'd0);
      checkOutput("reset_quotient", quotient, 32'd0);
      checkOutput("reset_remainder", remainder, 32'd0);
      checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
      resetn = 1'b1;

      // Non-divide opcode and cancel in IDLE must both block accept
      @(negedge clk);
      req = 1'b1; alucontrol = 8'h20; dividend = 32'd10; divisor = 32'd2;
      #1;
      checkOutput("otherOp_noStall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      alucontrol = EXE_DIVU_OP; cancel = 1'b1;
      #1;
      checkOutput("idleCancel_noStall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      req = 1'b0; cancel = 1'b0;
      #1;
      checkOutput("idleCancel_stillIdle", {31'b0, stall}, 32'd0);

      // Table-driven divides, each presented right after the previous DONE
      for (int i = 0; i < 11; i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         applyStimulus(nm, vecs[i].op, vecs[i].a, vecs[i].b);
         waitResult(nm, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat, vc1);
      end
      lastQ = vecs[10].q;
      lastR = vecs[10].r;

      // Cancel in the 10th BUSY cycle, then a fresh divide the next cycle
      applyStimulus("cancel", EXE_DIVU_OP, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      req = 1'b0; cancel = 1'b1;
      #1;
      checkOutput("cancel_stallDrops", {31'b0, stall}, 32'd0);
      checkOutput("cancel_noValid", {31'b0, valid}, 32'd0);
      checkOutput("cancel_quotientHeld", quotient, lastQ);
      checkOutput("cancel_remainderHeld", remainder, lastR);
      applyStimulus("afterCancel", EXE_DIVU_OP, 32'd20, 32'd6);
      checkOutput("afterCancel_quotientHeld", quotient, lastQ);
      waitResult("afterCancel", 32'd3, 32'd2, 1'b0, 33, vc1);

      // Asynchronous reset in BUSY cycle 5 clears all outputs immediately
      applyStimulus("midReset", EXE_DIVU_OP, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      req    = 1'b0;
      #1;
      checkOutput("midReset_stall", {31'b0, stall}, 32'd0);
      checkOutput("midReset_valid", {31'b0, valid}, 32'd0);
      checkOutput("midReset_quotient", quotient, 32'd0);
      checkOutput("midReset_remainder", remainder, 32'd0);
      checkOutput("midReset_dbz", {31'b0, div_by_zero}, 32'd0);
      repeat (2) @(negedge clk);
      checkOutput("midReset_noValidLater", {31'b0, valid}, 32'd0);
      resetn = 1'b1;

      // Back-to-back signed divides after reset: valids 34 cycles apart
      applyStimulus("b2b0", EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7);
      waitResult("b2b0", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, vc1);
      applyStimulus("b2b1", EXE_DIV_OP, 32'h8000_0000, 32'd3);
      waitResult("b2b1", 32'hD555_5556, 32'hFFFF_FFFE, 1'b0, 33, vc2);
      checkOutput("b2b_validSpacing", vc2 - vc1, 32'd34);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
